cnn_logit: RTL and testbench



---
 rtl/cnn_logit.sv | 137 +++++++++++++
 tb/tb_cnn_logit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_logit.sv
// cnn_logit: streaming inverse-sigmoid stage, x = ln(p / (1 - p)) on IEEE-754
// single-precision probabilities. Behavioural real-arithmetic model with domain
// classification, fixed 4-cycle latency, per-frame element count and done pulse.
module cnn_logit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_ELEMS  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] in,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  valid_out,
   output logic                  range_err,
   output logic                  done
);

   typedef enum logic [1:0] {
      CLS_NORMAL = 2'd0,
      CLS_ZERO   = 2'd1,
      CLS_ONE    = 2'd2,
      CLS_BAD    = 2'd3
   } cls_t;

   localparam logic [15:0] LAST_IDX = 16'(NUM_ELEMS - 1);

   // r = p / (1 - p) on a double bit pattern
   function automatic logic [63:0] ratio_bits(input logic [63:0] d);
      real p;
      p = $bitstoreal(d);
      return $realtobits(p / (1.0 - p));
   endfunction

   // natural log on a double bit pattern
   function automatic logic [63:0] ln_bits(input logic [63:0] d);
      return $realtobits($ln($bitstoreal(d)));
   endfunction

   // double -> single by truncation; low 8 bits of (e_d - 896) equal e_d[7:0] - 128
   function automatic logic [31:0] pack_single(input logic [63:0] x);
      if (x[62:0] == '0)
         return '0;
      return {x[63], x[59:52] - 8'd128, x[51:29]};
   endfunction

   cls_t        cls_in;
   logic        s1_valid, s2_valid, s3_valid, s4_valid;
   cls_t        s1_cls, s2_cls, s3_cls, s4_cls;
   logic [31:0] s1_bits;
   logic [63:0] s2_d, s3_r, s4_x;
   logic [15:0] count;

   // classify the incoming sample into its domain class
   always_comb begin
      cls_in = CLS_NORMAL;
      if (in[30:23] == '0)
         cls_in = CLS_ZERO;
      else if (in == 32'h3F80_0000)
         cls_in = CLS_ONE;
      else if (in[31] || in[30:23] == '1 || in[30:0] > 31'h3F80_0000)
         cls_in = CLS_BAD;
   end

   // pipeline: capture, widen to double, ratio, log, pack; idle stages hold data
   // The widening step is registered so the sampling edge plus four more edges
   // give the output, matching the fixed 4-cycle latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         s3_valid  <= 1'b0;
         s4_valid  <= 1'b0;
         s1_cls    <= CLS_NORMAL;
         s2_cls    <= CLS_NORMAL;
         s3_cls    <= CLS_NORMAL;
         s4_cls    <= CLS_NORMAL;
         s1_bits   <= '0;
         s2_d      <= '0;
         s3_r      <= '0;
         s4_x      <= '0;
         out       <= '0;
         valid_out <= 1'b0;
         range_err <= 1'b0;
         done      <= 1'b0;
         count     <= '0;
      end else begin
         s1_valid  <= valid_in;
         s2_valid  <= s1_valid;
         s3_valid  <= s2_valid;
         s4_valid  <= s3_valid;
         valid_out <= s4_valid;
         range_err <= 1'b0;
         done      <= 1'b0;

         if (valid_in) begin
            s1_cls  <= cls_in;
            s1_bits <= in;
         end

         if (s1_valid) begin
            s2_cls <= s1_cls;
            if (s1_cls == CLS_NORMAL)
               s2_d <= {s1_bits[31], {3'b000, s1_bits[30:23]} + 11'd896,
                        s1_bits[22:0], 29'd0};
         end

         if (s2_valid) begin
            s3_cls <= s2_cls;
            if (s2_cls == CLS_NORMAL)
               s3_r <= ratio_bits(s2_d);
         end

         if (s3_valid) begin
            s4_cls <= s3_cls;
            if (s3_cls == CLS_NORMAL)
               s4_x <= ln_bits(s3_r);
         end

         if (s4_valid) begin
            case (s4_cls)
               CLS_ZERO: out <= 32'hFF80_0000;
               CLS_ONE:  out <= 32'h7F80_0000;
               CLS_BAD:  out <= 32'h7FC0_0000;
               default:  out <= pack_single(s4_x);
            endcase
            range_err <= (s4_cls == CLS_BAD);
            if (count == LAST_IDX) begin
               count <= '0;
               done  <= 1'b1;
            end else begin
               count <= count + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cnn_logit.sv
// Self-checking bench for cnn_logit: directed special/frame/reset scenarios and
// a randomized run checked against a real-valued logit reference.
module tb_cnn_logit;

   localparam int unsigned N = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [31:0] in;
   logic [31:0] out;
   logic        valid_out;
   logic        range_err;
   logic        done;

   always #5 clk = ~clk;

   cnn_logit #(.DATA_WIDTH(32), .NUM_ELEMS(N)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .in(in),
      .out(out), .valid_out(valid_out), .range_err(range_err), .done(done)
   );

   typedef struct {
      logic [31:0] bits;
      longint      t;
   } item_t;

   int          checks = 0;
   int          errors = 0;
   longint      cyc = 0;
   int unsigned n_out = 0;
   logic [31:0] last_out = '0;
   item_t       q[$];
   logic [31:0] obs_out[$];
   logic        obs_err[$];
   logic        obs_done[$];

   // value of a single-precision pattern; zero exponent field reads as 0
   function automatic real sp_value(input logic [31:0] b);
      real v;
      int  e;
      if (b[30:23] == 8'd0) return 0.0;
      v = real'(32'(b[22:0]) + 32'd8388608);
      e = int'(b[30:23]) - 150;
      while (e > 0) begin v = v * 2.0; e--; end
      while (e < 0) begin v = v / 2.0; e++; end
      return b[31] ? -v : v;
   endfunction

   function automatic real ulp_of(input logic [31:0] b);
      real v;
      int  e;
      v = 1.0;
      e = int'(b[30:23]) - 150;
      while (e > 0) begin v = v * 2.0; e--; end
      while (e < 0) begin v = v / 2.0; e++; end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_elem(input item_t it);
      logic [31:0] b;
      real         v, r, d;
      logic        ok;
      b = it.bits;
      v = sp_value(b);
      chk("latency", 32'(cyc - it.t), 32'd4);
      if (b[30:23] == 8'd0) begin
         chk("zero_out", out, 32'hFF80_0000);
         chk("zero_err", {31'd0, range_err}, 32'd0);
      end else if (b[30:23] == 8'hFF || v < 0.0 || v > 1.0) begin
         chk("bad_out", out, 32'h7FC0_0000);
         chk("bad_err", {31'd0, range_err}, 32'd1);
      end else if (v == 1.0) begin
         chk("one_out", out, 32'h7F80_0000);
         chk("one_err", {31'd0, range_err}, 32'd0);
      end else begin
         r = $ln(v / (1.0 - v));
         chk("norm_err", {31'd0, range_err}, 32'd0);
         if (r == 0.0) begin
            chk("logit_zero", out, 32'h0000_0000);
         end else begin
            d = sp_value(out) - r;
            if (d < 0.0) d = -d;
            ok = (out[31] == (r < 0.0)) && out[30:23] != 8'd0 && out[30:23] != 8'hFF
                 && d <= ulp_of(out);
            checks++;
            assert (ok) else begin
               errors++;
               $error("FAIL logit observed=%h expected=%f p=%h", out, r, b);
            end
         end
      end
      chk("done", {31'd0, done}, {31'd0, (n_out % N) == N - 1});
      n_out++;
   endtask

   task automatic step(input logic v, input logic [31:0] d);
      logic  exp_valid;
      item_t it;
      valid_in = v;
      in       = d;
      @(posedge clk);
      cyc++;
      if (v) q.push_back('{d, cyc});
      #1;
      exp_valid = (q.size() > 0) && (cyc - q[0].t == 4);
      chk("valid_out", {31'd0, valid_out}, {31'd0, exp_valid});
      if (exp_valid) begin
         it = q.pop_front();
         if (valid_out) begin
            check_elem(it);
            obs_out.push_back(out);
            obs_err.push_back(range_err);
            obs_done.push_back(done);
            last_out = out;
         end
      end else begin
         chk("hold_out", out, last_out);
         chk("idle_err", {31'd0, range_err}, 32'd0);
         chk("idle_done", {31'd0, done}, 32'd0);
      end
   endtask

   // called right after a step: asserts reset mid-cycle, checks it, releases it
   task automatic do_reset();
      #2;
      reset = 1'b1;
      #1;
      chk("rst_out", out, 32'd0);
      chk("rst_valid", {31'd0, valid_out}, 32'd0);
      chk("rst_err", {31'd0, range_err}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      q.delete();
      n_out    = 0;
      last_out = '0;
      @(posedge clk);
      cyc++;
      #1;
      chk("rst_hold_valid", {31'd0, valid_out}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic clear_obs();
      obs_out.delete();
      obs_err.delete();
      obs_done.delete();
   endtask

   initial begin
      logic [31:0] spec_in[5];
      logic [31:0] spec_out[5];
      logic        spec_err[5];
      logic [31:0] bits;
      int          diff;
      int unsigned sent;

      reset    = 1'b1;
      valid_in = 1'b0;
      in       = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_out", out, 32'd0);
      chk("init_valid", {31'd0, valid_out}, 32'd0);
      chk("init_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) step(1'b0, '0);

      // basic values
      clear_obs();
      step(1'b1, 32'h3F00_0000);
      step(1'b1, 32'h3F40_0000);
      step(1'b1, 32'h3E80_0000);
      repeat (8) step(1'b0, '0);
      chk("basic_count", obs_out.size(), 32'd3);
      if (obs_out.size() == 3) begin
         chk("basic_half", obs_out[0], 32'h0000_0000);
         diff = int'(obs_out[1]) - int'(32'h3F8C_9F53);
         chk("basic_075_ulp", {31'd0, diff >= -1 && diff <= 1}, 32'd1);
         diff = int'(obs_out[2]) - int'(32'hBF8C_9F53);
         chk("basic_025_ulp", {31'd0, diff >= -1 && diff <= 1}, 32'd1);
      end

      // special values
      spec_in  = '{32'h0000_0000, 32'h3F80_0000, 32'h3F80_0001, 32'hBE80_0000, 32'h7FC0_0000};
      spec_out = '{32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000};
      spec_err = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      clear_obs();
      for (int i = 0; i < 5; i++) step(1'b1, spec_in[i]);
      repeat (8) step(1'b0, '0);
      chk("spec_count", obs_out.size(), 32'd5);
      if (obs_out.size() == 5)
         for (int i = 0; i < 5; i++) begin
            chk("spec_out", obs_out[i], spec_out[i]);
            chk("spec_err", {31'd0, obs_err[i]}, {31'd0, spec_err[i]});
         end

      // frame counting with random gaps
      do_reset();
      clear_obs();
      for (int i = 0; i < 10; i++) begin
         step(1'b1, {1'b0, 8'($urandom_range(100, 126)), 23'($urandom)});
         repeat ($urandom_range(0, 3)) step(1'b0, '0);
      end
      repeat (8) step(1'b0, '0);
      chk("frame_count", obs_done.size(), 32'd10);
      if (obs_done.size() == 10)
         for (int i = 0; i < 10; i++)
            chk("frame_done", {31'd0, obs_done[i]}, {31'd0, i == 3 || i == 7});

      // reset mid-stream: in-flight elements are discarded
      clear_obs();
      step(1'b1, 32'h3F00_0000);
      step(1'b1, 32'h3F40_0000);
      step(1'b1, 32'h3E80_0000);
      step(1'b0, '0);
      do_reset();
      chk("mid_none", obs_out.size(), 32'd0);
      for (int i = 0; i < 4; i++) step(1'b1, 32'h3E00_0000);
      repeat (8) step(1'b0, '0);
      chk("mid_count", obs_out.size(), 32'd4);
      if (obs_done.size() == 4)
         for (int i = 0; i < 4; i++)
            chk("mid_done", {31'd0, obs_done[i]}, {31'd0, i == 3});

      // randomized probabilities in (0, 1) with random gaps
      sent = 0;
      while (sent < 10000) begin
         if ($urandom_range(0, 9) != 0) begin
            bits = {1'b0, 8'($urandom_range(1, 126)), 23'($urandom)};
            step(1'b1, bits);
            sent++;
         end else begin
            step(1'b0, '0);
         end
      end
      repeat (8) step(1'b0, '0);
      chk("drain_empty", q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
